data_memory_ws: RTL and testbench

Parametrised successor to the single-cycle data memory. It is a byte-addressed, little-endian, word-organised data RAM with byte, halfword and word loads and stores, and sign or zero extension on loads. It uses a valid/ready request and one-cycle response handshake with a configurable number of wait states. Reset clears the array one word per cycle, and bad accesses are flagged instead of silently aliasing. It sits in the MEM stage of the MIPS core, or behind a stall controller in the multicycle variant.

---
 rtl/data_mem_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/data_memory_ws.sv | 166 ++++++++++++++++
 tb/tb_data_memory_ws.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// ============================================================================
// data_mem_pkg : size encodings, FSM state type and byte-enable helper
// Rev 1.0
// ============================================================================
`default_nettype none

package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lane;
      SIZE_HALF: mask = 4'b0011 << lane;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : store lane replication / byte enables, load extraction
//                  with sign/zero extension, and alignment check
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_isUnsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wdataRep,
  output logic [3:0]  o_byteEn,
  output logic [31:0] o_rdataExt,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;
  logic        w_signBit;

  assign o_byteEn  = lane_mask(i_size, i_lane);
  assign w_shifted = i_rword >> {i_lane, 3'b000};

  always_comb begin
    o_wdataRep = i_wdata;
    case (i_size)
      SIZE_BYTE: o_wdataRep = {4{i_wdata[7:0]}};
      SIZE_HALF: o_wdataRep = {2{i_wdata[15:0]}};
      default:   o_wdataRep = i_wdata;
    endcase
  end

  // Word loads are only legal at lane 0, so the shifted word equals the raw word.
  always_comb begin
    w_signBit  = 1'b0;
    o_rdataExt = w_shifted;
    case (i_size)
      SIZE_BYTE: begin
        w_signBit  = ~i_isUnsigned & w_shifted[7];
        o_rdataExt = {{24{w_signBit}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        w_signBit  = ~i_isUnsigned & w_shifted[15];
        o_rdataExt = {{16{w_signBit}}, w_shifted[15:0]};
      end
      default: o_rdataExt = w_shifted;
    endcase
  end

  assign o_misaligned = ((i_size == SIZE_HALF) && i_lane[0]) ||
                        ((i_size == SIZE_WORD) && (i_lane != 2'b00));

endmodule

`default_nettype wire

// File: rtl/data_memory_ws.sv
// ============================================================================
// data_memory_ws : byte-addressed word RAM with valid/ready request,
//                  configurable wait states, clear-on-reset and error flagging
// Rev 1.0
// ============================================================================
`default_nettype none

module data_memory_ws
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_busy
);

  localparam int                 c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam int                 c_CLR_W    = c_IDX_W + 1;
  localparam logic [c_CLR_W-1:0] c_LAST_IDX = c_CLR_W'(DEPTH_WORDS - 1);
  localparam logic [3:0]         c_WAIT     = 4'(WAIT_CYCLES);

  state_t               r_state;
  state_t               w_nextState;
  logic [c_CLR_W-1:0]   r_clrIdx;
  logic [3:0]           r_wcnt;
  logic                 r_write;
  logic [ADDR_W-1:0]    r_addr;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [31:0]          r_wdata;
  logic [31:0]          r_respRdata;
  logic                 r_respErr;
  logic [31:0]          r_mem [DEPTH_WORDS];

  logic                 w_inIdle;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_curWrite;
  logic [ADDR_W-1:0]    w_curAddr;
  logic [1:0]           w_curSize;
  logic                 w_curUnsigned;
  logic [31:0]          w_curWdata;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_oob;
  logic                 w_misaligned;
  logic                 w_err;
  logic [31:0]          w_wdataRep;
  logic [3:0]           w_byteEn;
  logic [31:0]          w_rdataExt;

  assign w_inIdle   = (r_state == IDLE);
  assign w_accept   = req_valid & w_inIdle;
  assign req_ready  = w_inIdle;
  assign resp_valid = (r_state == RESP);
  assign init_busy  = (r_state == CLEAR);
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

  // With zero wait states the commit edge is the acceptance edge, so the live
  // request fields must feed the datapath while idle.
  assign w_curWrite    = w_inIdle ? req_write    : r_write;
  assign w_curAddr     = w_inIdle ? req_addr     : r_addr;
  assign w_curSize     = w_inIdle ? req_size     : r_size;
  assign w_curUnsigned = w_inIdle ? req_unsigned : r_unsigned;
  assign w_curWdata    = w_inIdle ? req_wdata    : r_wdata;

  assign w_idx = w_curAddr[c_IDX_W+1:2];

  generate
    if (ADDR_W > c_IDX_W + 2) begin : g_oob_check
      assign w_oob = |w_curAddr[ADDR_W-1:c_IDX_W+2];
    end else begin : g_oob_none
      assign w_oob = 1'b0;
    end
  endgenerate

  mem_lane_align u_align (
    .i_size       (w_curSize),
    .i_lane       (w_curAddr[1:0]),
    .i_isUnsigned (w_curUnsigned),
    .i_wdata      (w_curWdata),
    .i_rword      (r_mem[w_idx]),
    .o_wdataRep   (w_wdataRep),
    .o_byteEn     (w_byteEn),
    .o_rdataExt   (w_rdataExt),
    .o_misaligned (w_misaligned)
  );

  assign w_err = w_oob | w_misaligned | (w_curSize == SIZE_RSVD);

  always_ff @(posedge clk) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CLEAR:   if (r_clrIdx == c_LAST_IDX) w_nextState = IDLE;
      IDLE:    if (w_accept) w_nextState = (c_WAIT == 4'd0) ? RESP : WAIT;
      WAIT:    if (r_wcnt <= 4'd1) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = CLEAR;
    endcase
  end

  assign w_commit = ~reset && (w_nextState == RESP) && (r_state != RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clrIdx    <= '0;
      r_wcnt      <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_size      <= SIZE_BYTE;
      r_unsigned  <= 1'b0;
      r_wdata     <= 32'd0;
      r_respRdata <= 32'd0;
      r_respErr   <= 1'b0;
    end else begin
      if (r_state == CLEAR) r_clrIdx <= r_clrIdx + 1'b1;
      if (w_accept) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
        r_wcnt     <= c_WAIT;
      end else if (r_state == WAIT) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (w_commit) begin
        r_respErr   <= w_err;
        r_respRdata <= (w_err || w_curWrite) ? 32'd0 : w_rdataExt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_clrIdx[c_IDX_W-1:0]] <= 32'd0;
      end else if (w_commit && !w_err && w_curWrite) begin
        for (int k = 0; k < 4; k++) begin
          if (w_byteEn[k]) r_mem[w_idx][8*k +: 8] <= w_wdataRep[8*k +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ws.sv
// ============================================================================
// tb_data_memory_ws : directed vector bench for data_memory_ws (0 and 3 waits)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_ws;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        valid [2];
  logic        ready [2];
  logic        rv    [2];
  logic        er    [2];
  logic        busy  [2];
  logic [31:0] rd    [2];
  logic        wr;
  logic [31:0] addr;
  logic [1:0]  sz;
  logic        un;
  logic [31:0] wd;

  int nChecks = 0;
  int nFail   = 0;

  data_memory_ws #(.ADDR_W(32), .DEPTH_WORDS(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_write(wr), .req_addr(addr), .req_size(sz), .req_unsigned(un),
    .req_wdata(wd), .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]),
    .init_busy(busy[0])
  );

  data_memory_ws #(.ADDR_W(32), .DEPTH_WORDS(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_write(wr), .req_addr(addr), .req_size(sz), .req_unsigned(un),
    .req_wdata(wd), .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]),
    .init_busy(busy[1])
  );

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic        expErr;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] d, input logic [31:0] e, input logic ee, input string n);
    vec_t v;
    v.wr = w; v.a = a; v.sz = s; v.un = u; v.wd = d; v.expRd = e; v.expErr = ee; v.name = n;
    vt.push_back(v);
  endtask

  // One request on DUT d; checks data, error, latency and single-cycle pulse.
  task automatic doReq(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] dat, input logic [31:0] expRd,
                       input logic expErr, input int expLat, input string name);
    int n;
    int lat;
    @(negedge clk);
    wr = w; addr = a; sz = s; un = u; wd = dat; valid[d] = 1'b1;
    n = 0;
    while (!ready[d] && n < 100) begin @(negedge clk); n++; end
    if (!ready[d]) begin
      valid[d] = 1'b0;
      check({name, " ready timeout"}, 32'(ready[d]), 32'd1);
      return;
    end
    @(negedge clk);
    valid[d] = 1'b0;
    wr = 1'b0; addr = 32'hFFFF_FFFF; sz = SIZE_RSVD; un = 1'b1; wd = 32'hA5A5_A5A5;
    lat = 1;
    while (!rv[d] && lat < 20) begin @(negedge clk); lat++; end
    check({name, " resp seen"}, 32'(rv[d]), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(expLat));
    check({name, " rdata"}, rd[d], expRd);
    check({name, " err"}, 32'(er[d]), 32'(expErr));
    @(negedge clk);
    check({name, " pulse width"}, 32'(rv[d]), 32'd0);
    check({name, " ready after"}, 32'(ready[d]), 32'd1);
  endtask

  initial begin
    int n0, n1, bad, nResp;
    rst[0] = 1'b1; rst[1] = 1'b1; valid[0] = 1'b0; valid[1] = 1'b0;
    wr = 1'b0; addr = 32'd0; sz = SIZE_WORD; un = 1'b0; wd = 32'd0;

    // Reset for one edge, then both arrays clear in parallel.
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    check("reset busy", 32'(busy[0]), 32'd1);
    check("reset ready", 32'(ready[0]), 32'd0);
    check("reset resp_valid", 32'(rv[0]), 32'd0);
    check("reset rdata", rd[0], 32'd0);
    check("reset err", 32'(er[0]), 32'd0);
    n0 = 0; n1 = 0; bad = 0;
    for (int c = 0; c < 100 && (busy[0] || busy[1]); c++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if ((busy[0] && ready[0]) || (busy[1] && ready[1]) || rv[0] || rv[1]) bad++;
      @(negedge clk);
    end
    check("clear cycles w0", 32'(n0), 32'd32);
    check("clear cycles w3", 32'(n1), 32'd32);
    check("clear ready/resp violations", 32'(bad), 32'd0);
    check("ready after clear", 32'(ready[0]), 32'd1);

    addv(0, 32'h7C, SIZE_WORD, 0, 0, 32'h0000_0000, 0, "lw 0x7C cleared");
    addv(1, 32'h1C, SIZE_WORD, 0, 32'hDEAD_BEEF, 32'h0, 0, "sw 0x1C");
    addv(0, 32'h1C, SIZE_WORD, 0, 0, 32'hDEAD_BEEF, 0, "lw 0x1C");
    addv(1, 32'h1D, SIZE_BYTE, 0, 32'h1234_5680, 32'h0, 0, "sb 0x1D");
    addv(0, 32'h1D, SIZE_BYTE, 0, 0, 32'hFFFF_FF80, 0, "lb 0x1D");
    addv(0, 32'h1D, SIZE_BYTE, 1, 0, 32'h0000_0080, 0, "lbu 0x1D");
    addv(0, 32'h1C, SIZE_WORD, 0, 0, 32'hDEAD_80EF, 0, "lw 0x1C after sb");
    addv(0, 32'h1E, SIZE_HALF, 1, 0, 32'h0000_DEAD, 0, "lhu 0x1E");
    addv(0, 32'h1E, SIZE_HALF, 0, 0, 32'hFFFF_DEAD, 0, "lh 0x1E");
    addv(0, 32'h01, SIZE_HALF, 0, 0, 32'h0, 1, "lh 0x01 misaligned");
    addv(1, 32'h1E, SIZE_WORD, 0, 32'h1234_5678, 32'h0, 1, "sw 0x1E misaligned");
    addv(0, 32'h80, SIZE_WORD, 0, 0, 32'h0, 1, "lw 0x80 out of range");
    addv(1, 32'h1C, SIZE_RSVD, 0, 32'hFFFF_FFFF, 32'h0, 1, "reserved size store");
    addv(1, 32'h81, SIZE_BYTE, 0, 32'h0000_0077, 32'h0, 1, "sb 0x81 out of range");
    addv(0, 32'h8000_001C, SIZE_WORD, 0, 0, 32'h0, 1, "lw high addr bit");
    addv(0, 32'h1C, SIZE_WORD, 0, 0, 32'hDEAD_80EF, 0, "lw 0x1C after errors");
    addv(0, 32'h00, SIZE_WORD, 0, 0, 32'h0, 0, "lw 0x00 no alias");
    addv(1, 32'h02, SIZE_HALF, 0, 32'hAAAA_BEEF, 32'h0, 0, "sh 0x02");
    addv(0, 32'h00, SIZE_WORD, 1, 0, 32'hBEEF_0000, 0, "lw 0x00 after sh");
    addv(0, 32'h03, SIZE_BYTE, 0, 0, 32'hFFFF_FFBE, 0, "lb 0x03");
    addv(0, 32'h02, SIZE_BYTE, 1, 0, 32'h0000_00EF, 0, "lbu 0x02");

    foreach (vt[i])
      doReq(0, vt[i].wr, vt[i].a, vt[i].sz, vt[i].un, vt[i].wd,
            vt[i].expRd, vt[i].expErr, 1, vt[i].name);

    // Three wait states: plain store/load and an error, latency four.
    doReq(1, 1, 32'h08, SIZE_WORD, 0, 32'h0000_0055, 32'h0, 0, 4, "w3 sw 0x08");
    doReq(1, 0, 32'h08, SIZE_WORD, 0, 32'h0, 32'h0000_0055, 0, 4, "w3 lw 0x08");
    doReq(1, 0, 32'h01, SIZE_HALF, 0, 32'h0, 32'h0, 1, 4, "w3 lh 0x01");

    // Back-to-back with req_valid held: one acceptance every five cycles.
    wr = 1'b0; addr = 32'h08; sz = SIZE_WORD; un = 1'b0; valid[1] = 1'b1;
    bad = 0; nResp = 0;
    for (int c = 0; c < 15; c++) begin
      if (ready[1] !== ((c % 5) == 0)) bad++;
      if (rv[1] !== ((c % 5) == 4)) bad++;
      if (rv[1]) begin
        nResp++;
        check("w3 stream rdata", rd[1], 32'h0000_0055);
      end
      @(negedge clk);
    end
    valid[1] = 1'b0;
    check("w3 stream handshake pattern", 32'(bad), 32'd0);
    check("w3 stream responses", 32'(nResp), 32'd3);

    // Reset during the second WAIT cycle drops the pending store.
    wr = 1'b1; addr = 32'h08; sz = SIZE_WORD; wd = 32'h0000_0055; valid[1] = 1'b1;
    check("w3 pre-reset ready", 32'(ready[1]), 32'd1);
    @(negedge clk);
    valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("w3 busy after mid reset", 32'(busy[1]), 32'd1);
    n1 = 0; bad = 0;
    for (int c = 0; c < 100 && busy[1]; c++) begin
      n1++;
      if (rv[1] || ready[1]) bad++;
      @(negedge clk);
    end
    check("w3 clear cycles after mid reset", 32'(n1), 32'd32);
    check("w3 no resp during clear", 32'(bad), 32'd0);
    doReq(1, 0, 32'h08, SIZE_WORD, 0, 32'h0, 32'h0000_0000, 0, 4, "w3 lw 0x08 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
